decimal_to_bcd_encoder: RTL and testbench

DECIMAL_TO_BCD_ENCODER -- requirements
Module: decimal_to_bcd_encoder

---
 rtl/decimal_to_bcd_encoder_pkg.sv | 36 +++
 rtl/decimal_to_bcd_encoder_key_stabilizer.sv | 58 +++++
 rtl/decimal_to_bcd_encoder.sv | 99 +++++++++
 tb/tb_decimal_to_bcd_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_to_bcd_encoder_pkg.sv
// Shared types and constants for the decimal key to BCD encoder.
// Holds the FSM state enum, digit/BCD widths and the key encoding function.
package decimal_pkg;

  localparam int DIGITS = 10;
  localparam int BCD_W  = 4;
  localparam int CNT_W  = 8;
  localparam logic [BCD_W-1:0] BCD_ERR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Returns {err, bcd}: a lone pressed key gives its digit, anything else is an error.
  function automatic logic [BCD_W:0] encode_key(input logic [DIGITS-1:0] key);
    int unsigned      ones;
    logic [BCD_W-1:0] idx;
    ones = 0;
    idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (key[i]) begin
        ones = ones + 1;
        idx  = BCD_W'(i);
      end
    end
    if (ones == 1) begin
      return {1'b0, idx};
    end else begin
      return {1'b1, BCD_ERR};
    end
  endfunction

endpackage

// File: rtl/decimal_to_bcd_encoder_key_stabilizer.sv
// Snapshot register and run-length counter for the key lines.
// Pulses stable on the edge at which the held pattern completes its debounce run.
module key_stabilizer
  import decimal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIGITS-1:0] key,
  input  logic              idle,
  input  logic              debouncing,
  output logic              stable
);

  localparam logic [CNT_W:0] TARGET = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam bit             SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [DIGITS-1:0] snapshot_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DIGITS-1:0] bit_match;
  logic [CNT_W:0]    count_inc;
  logic              same;
  logic              key_any;
  logic              load;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_match
      assign bit_match[gi] = key[gi] ~^ snapshot_reg[gi];
    end
  endgenerate

  assign same      = &bit_match;
  assign key_any   = |key;
  assign count_inc = {1'b0, count_reg} + (CNT_W+1)'(1);
  // A new nonzero pattern (from idle, or a change mid-debounce) restarts the run at one.
  assign load      = key_any && (idle || (debouncing && !same));

  assign stable = key_any &&
                  ((idle && SINGLE) || (debouncing && same && (count_inc == TARGET)));

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot_reg <= '0;
      count_reg    <= '0;
    end else if (load) begin
      snapshot_reg <= key;
      count_reg    <= CNT_W'(1);
    end else if (debouncing && key_any) begin
      count_reg    <= count_inc[CNT_W-1:0];
    end else if (debouncing) begin
      snapshot_reg <= '0;
      count_reg    <= '0;
    end
  end

endmodule

// File: rtl/decimal_to_bcd_encoder.sv
// Debounced decimal keypad to BCD encoder with valid/ready output handshake.
// One code per press: a key must be fully released before the next code is produced.
module decimal_to_bcd_encoder
  import decimal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIGITS-1:0] key,
  input  logic              ready,
  output logic [BCD_W-1:0]  bcd,
  output logic              valid,
  output logic              err,
  output logic              busy
);

  state_t           state_reg, state_next;
  logic             stable;
  logic             key_any;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic             err_reg, err_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;

  assign key_any = |key;

  key_stabilizer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stabilizer (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .idle       (state_reg == ST_IDLE),
    .debouncing (state_reg == ST_DEBOUNCE),
    .stable     (stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (stable)       state_next = ST_PRESENT;
        else if (key_any) state_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (stable)        state_next = ST_PRESENT;
        else if (!key_any) state_next = ST_IDLE;
      end
      ST_PRESENT: begin
        if (ready) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!key_any) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The result is captured only on the completing debounce edge, so it holds
  // through PRESENT and after the handshake regardless of later key activity.
  always_comb begin
    bcd_next   = bcd_reg;
    err_next   = err_reg;
    if (stable) begin
      {err_next, bcd_next} = encode_key(key);
    end
    valid_next = (state_next == ST_PRESENT);
    busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg   <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      bcd_reg   <= bcd_next;
      err_reg   <= err_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  assign bcd   = bcd_reg;
  assign err   = err_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Self-checking bench for decimal_to_bcd_encoder (default debounce of 4 cycles).
// Directed scenarios plus randomized presses checked against an arithmetic reference.
module tb_decimal_to_bcd_encoder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key;
  logic       ready;
  logic [3:0] bcd;
  logic       valid;
  logic       err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  decimal_to_bcd_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .ready (ready),
    .bcd   (bcd),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a single pressed key is its own digit (log2 of the one-hot), else error.
  function automatic logic [4:0] ref_encode(input logic [9:0] p);
    if ($countones(p) == 1) return {1'b0, 4'($clog2(p))};
    return {1'b1, 4'hF};
  endfunction

  task automatic settle();
    key   = '0;
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key = 10'b0000001000; ready = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({valid, busy, err, bcd} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b busy=%b err=%b bcd=%h, want all 0", valid, busy, err, bcd);
    end
    rst = 1'b0; key = '0; ready = 1'b0;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_single_digit();
    key = 10'b0000100000; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (valid !== (i == N-1)) begin
        tests_failed++;
        $display("FAIL single_valid[%0d]: got %b want %b", i, valid, (i == N-1));
      end
      if (i == N-1) begin
        tests_run++;
        if ({err, bcd} !== 5'h05) begin
          tests_failed++;
          $display("FAIL single_code: got err=%b bcd=%h want err=0 bcd=5", err, bcd);
        end
      end
    end
    $display("[TB] single digit 5 bcd=%h", bcd);
    settle();
  endtask

  task automatic test_change();
    int pulses = 0;
    int at     = -1;
    logic [3:0] got = 'x;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      key = (i < 2) ? 10'b0000001000 : 10'b0010000000;
      tick();
      if (valid) begin pulses++; at = i; got = bcd; end
    end
    tests_run++;
    if (pulses !== 1 || at !== 2+N-1 || got !== 4'd7) begin
      tests_failed++;
      $display("FAIL change_digit: got pulses=%0d at=%0d bcd=%h want 1 at %0d bcd=7", pulses, at, got, 2+N-1);
    end
    $display("[TB] change 3->7 pulses=%0d bcd=%h", pulses, got);
    settle();
  endtask

  task automatic test_multi();
    key = 10'b1000000001; ready = 1'b0;
    repeat (N) tick();
    tests_run++;
    if ({valid, err, bcd} !== 6'b1_1_1111) begin
      tests_failed++;
      $display("FAIL multi_key: got valid=%b err=%b bcd=%h want 1 1 f", valid, err, bcd);
    end
    ready = 1'b1;
    tick();
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_handshake: got valid=%b busy=%b want 0 1", valid, busy);
    end
    $display("[TB] multi-key err=%b bcd=%h", err, bcd);
    settle();
  endtask

  task automatic test_hold();
    key = 10'b1000000000; ready = 1'b0;
    repeat (N) tick();
    key = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({valid, busy, err, bcd} !== 7'b1_1_0_1001) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: got valid=%b busy=%b err=%b bcd=%h want 1 1 0 9", i, valid, busy, err, bcd);
      end
    end
    ready = 1'b1;
    tick();
    tests_run++;
    if ({valid, busy, bcd} !== 6'b0_1_1001) begin
      tests_failed++;
      $display("FAIL hold_ack: got valid=%b busy=%b bcd=%h want 0 1 9", valid, busy, bcd);
    end
    ready = 1'b0;
    tick();
    tests_run++;
    if ({valid, busy, bcd} !== 6'b0_0_1001) begin
      tests_failed++;
      $display("FAIL hold_idle: got valid=%b busy=%b bcd=%h want 0 0 9", valid, busy, bcd);
    end
    $display("[TB] hold digit 9 acked");
    settle();
  endtask

  task automatic test_back_to_back();
    int pulses;
    ready = 1'b1;
    for (int press = 0; press < 2; press++) begin
      pulses = 0;
      key = 10'b0000000100;
      for (int i = 0; i < ((press == 0) ? 20 : 6); i++) begin
        tick();
        if (valid) pulses++;
      end
      key = '0;
      repeat (2) begin tick(); if (valid) pulses++; end
      tests_run++;
      if (pulses !== 1) begin
        tests_failed++;
        $display("FAIL b2b_press%0d: got %0d pulses want 1", press, pulses);
      end
      $display("[TB] press %0d of digit 2 pulses=%0d", press, pulses);
    end
    settle();
  endtask

  task automatic test_reset_present();
    key = 10'b0000010000; ready = 1'b0;
    repeat (N) tick();
    tests_run++;
    if (valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstp_pre: got valid=%b want 1", valid);
    end
    rst = 1'b1; ready = 1'b1;
    tick();
    tests_run++;
    if ({valid, busy, err, bcd} !== 7'b0) begin
      tests_failed++;
      $display("FAIL rstp_clear: got valid=%b busy=%b err=%b bcd=%h want all 0", valid, busy, err, bcd);
    end
    rst = 1'b0; ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      tests_run++;
      if (valid !== (i == N-1)) begin
        tests_failed++;
        $display("FAIL rstp_redebounce[%0d]: got valid=%b want %b", i, valid, (i == N-1));
      end
    end
    tests_run++;
    if (bcd !== 4'd4) begin
      tests_failed++;
      $display("FAIL rstp_code: got bcd=%h want 4", bcd);
    end
    $display("[TB] reset in present, re-debounced bcd=%h", bcd);
    settle();
  endtask

  task automatic test_random();
    logic [9:0] p;
    logic [4:0] exp_code, got_code;
    int len, pulses, at;
    for (int t = 0; t < 25; t++) begin
      p = 10'(1) << $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) p = p | (10'(1) << $urandom_range(0, 9));
      len = $urandom_range(1, 8);
      exp_code = ref_encode(p);
      pulses = 0; at = -1; got_code = 'x;
      ready = 1'b1;
      key = p;
      for (int i = 0; i < len; i++) begin
        tick();
        if (valid) begin pulses++; at = i; got_code = {err, bcd}; end
      end
      key = '0;
      repeat (3) begin tick(); if (valid) pulses++; end
      tests_run++;
      if (len >= N) begin
        if (pulses !== 1 || at !== N-1 || got_code !== exp_code) begin
          tests_failed++;
          $display("FAIL random[%0d]: key=%b len=%0d got pulses=%0d at=%0d code=%h want 1 at %0d code=%h",
                   t, p, len, pulses, at, got_code, N-1, exp_code);
        end
      end else if (pulses !== 0) begin
        tests_failed++;
        $display("FAIL random[%0d]: key=%b len=%0d got %0d pulses want 0", t, p, len, pulses);
      end
      $display("[TB] random %0d key=%b len=%0d pulses=%0d code=%h", t, p, len, pulses, got_code);
    end
    settle();
  endtask

  initial begin
    rst = 1'b1; key = '0; ready = 1'b0;
    test_reset();
    test_single_digit();
    test_change();
    test_multi();
    test_hold();
    test_back_to_back();
    test_reset_present();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
